fifo_buffer: RTL and testbench



---
 rtl/fifo_buffer_pkg.sv | 19 +
 rtl/fifo_ptr.sv | 35 +++
 rtl/fifo_reg.sv | 35 +++
 rtl/fifo_buffer.sv | 102 ++++++++++
 tb/tb_fifo_buffer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_buffer_pkg.sv
// Shared definitions for the fifo_buffer slice: default sizing and the
// per-edge update classification used by the occupancy counter.
package fifo_buffer_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 8;
  localparam int unsigned FIFO_DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    fifo_op = fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with increment, synchronous clear and async reset.
module fifo_ptr #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_d;
  logic [W-1:0] ptr_q;

  // Wraps from 2**W-1 to 0 by natural overflow.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_reg.sv
// Single-word register with load enable and synchronous clear; one per FIFO entry.
module fifo_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fifo_buffer.sv
// First-word-fall-through synchronous FIFO with valid/ready ports, synchronous
// flush, occupancy count and full/empty/almost_full status.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned WIDTH       = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH       = FIFO_DEF_DEPTH,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic             push_eff;
  logic             pop_eff;
  fifo_op_e         op;
  logic [WIDTH-1:0] entry [DEPTH];

  // Status is derived only from the registered count, so no input reaches an output.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign count       = count_q;
  assign out_data    = entry[rd_ptr];

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign push_eff = push & ~clear;
  assign pop_eff  = pop & ~clear;
  assign op       = fifo_op(push_eff, pop_eff);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      unique case (op)
        OP_PUSH: count_d = count_q + CNT_W'(1);
        OP_POP:  count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  fifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (push_eff),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (pop_eff),
    .ptr   (rd_ptr)
  );

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
    fifo_reg #(.W(WIDTH)) u_entry (
      .clock (clock),
      .reset (reset),
      .en    (push_eff && (wr_ptr == PTR_W'(i))),
      .clear (1'b0),
      .d     (in_data),
      .q     (entry[i])
    );
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer at WIDTH=8, DEPTH=4.
module tb_fifo_buffer;

  logic       clock;
  logic       reset;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;

  int checks;
  int errors;

  fifo_buffer #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [7:0] exp);
    check(tag, 32'(out_valid), 32'd1);
    check(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] fill [4];
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Fill to full; almost_full from count 3.
    for (int i = 0; i < 4; i++) begin
      push_word(fill[i]);
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_afull", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
      check("fill_head", 32'(out_data), 32'h11);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);

    push_word(8'h55);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_head", 32'(out_data), 32'h11);

    for (int i = 0; i < 4; i++) pop_word("drain_data", fill[i]);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);

    // Underflow attempt leaves state unchanged.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("udf_count", 32'(count), 32'd0);
    check("udf_out_valid", 32'(out_valid), 32'd0);

    // Move pointers to 3, then push A0..A3 across the wrap.
    for (int i = 0; i < 3; i++) push_word(8'(i + 1));
    for (int i = 0; i < 3; i++) pop_word("pre_wrap", 8'(i + 1));
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) pop_word("wrap_data", 8'hA0 + 8'(i));
    check("wrap_count", 32'(count), 32'd0);

    // Streaming at count 2: output trails input by two words.
    push_word(8'h10);
    push_word(8'h11);
    for (int k = 0; k < 10; k++) begin
      check("stream_head", 32'(out_data), 32'(8'h10 + 8'(k)));
      in_valid  = 1'b1;
      in_data   = 8'h12 + 8'(k);
      out_ready = 1'b1;
      step();
      check("stream_count", 32'(count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pop_word("stream_tail", 8'h1A);
    pop_word("stream_tail", 8'h1B);
    check("stream_empty", 32'(empty), 32'd1);

    // Clear dominates a simultaneous push and pop.
    push_word(8'h61);
    push_word(8'h62);
    push_word(8'h63);
    check("pre_clr_count", 32'(count), 32'd3);
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    push_word(8'h7E);
    check("post_clr_count", 32'(count), 32'd1);
    pop_word("post_clr_data", 8'h7E);

    // Asynchronous reset between clock edges.
    push_word(8'h01);
    push_word(8'h02);
    check("pre_arst_count", 32'(count), 32'd2);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    step();
    reset = 1'b0;
    #1;
    check("arst_release_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
